// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and helpers for the 4-phase req/ack CDC sender.
// Exports the FSM state type and the timeout counter width function.
package cdc_hs_pkg;

    // 2'b11 is unused and recovers to IDLE on the next edge.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // Width to hold 0..cycles, clamped to the 8..16 bit range.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8) w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/cdc_hs_tx_ctrl_if.sv
// cdc_hs_tx_ctrl_if: source valid/ready bus, req/data to the destination,
// async ack back, and the done/timeout pulses. master = source/dest side.
interface cdc_hs_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  tx_req;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  ack_async;
    logic                  xfer_done;
    logic                  timeout_err;

    modport master (
        output src_valid, src_data, ack_async,
        input  src_ready, tx_req, tx_data, xfer_done, timeout_err
    );

    modport slave (
        input  src_valid, src_data, ack_async,
        output src_ready, tx_req, tx_data, xfer_done, timeout_err
    );
endinterface

// File: rtl/cdc_sync_chain.sv
// cdc_sync_chain: NUM_STAGES-deep flop chain with async active-high reset.
// Ports: clk, rst, d (async input), q (d delayed by NUM_STAGES edges).
module cdc_sync_chain #(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stg [NUM_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < NUM_STAGES; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[NUM_STAGES-1];
endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// cdc_hs_tx_ctrl: source-side 4-phase req/ack controller for a multi-bit CDC.
// Ports: clk, rst (async, active-high), bus (cdc_hs_tx_ctrl_if.slave).
// Optional ack timeout abort enabled by defining CDC_TIMEOUT_EN.
module cdc_hs_tx_ctrl
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    cdc_hs_tx_ctrl_if.slave  bus
);
    state_t                state;
    logic                  ack_s;
    logic                  req_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  expire;

    cdc_sync_chain #(
        .NUM_STAGES (NUM_STAGES),
        .WIDTH      (1)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ack_async),
        .q   (ack_s)
    );

`ifdef CDC_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    // cnt_q holds cycles already spent in REQ before this edge.
    assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign expire     = 1'b0;
`endif

    // A lingering ack from the previous transfer blocks new accepts.
    assign bus.src_ready   = (state == ST_IDLE) && !ack_s;
    assign bus.tx_req      = req_q;
    assign bus.tx_data     = data_q;
    assign bus.xfer_done   = done_q;
    assign bus.timeout_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            req_q  <= 1'b0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef CDC_TIMEOUT_EN
            cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.src_valid && !ack_s) begin
                        data_q <= bus.src_data;
                        req_q  <= 1'b1;
                        state  <= ST_REQ;
`ifdef CDC_TIMEOUT_EN
                        cnt_q  <= '0;
`endif
                    end
                end
                ST_REQ: begin
`ifdef CDC_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= ST_RELEASE;
                    end else if (expire) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// tb_cdc_hs_tx_ctrl: directed scenarios plus a randomized run checked
// against a transaction-age model of the req/ack handshake.
module tb_cdc_hs_tx_ctrl;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack_mode = 1'b0;
    logic ack_force = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cdc_hs_tx_ctrl_if #(.DATA_WIDTH(DW)) bus();

    // Zero-delay destination echoes req, unless the ack is forced.
    assign bus.ack_async = ack_mode ? ack_force : bus.tx_req;

    cdc_hs_tx_ctrl #(
        .DATA_WIDTH     (DW),
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        ack_mode = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.tx_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%b want=0", bus.tx_req);
        end
        total++;
        if (bus.tx_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h want=00", bus.tx_data);
        end
        total++;
        if (bus.xfer_done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b want=0", bus.xfer_done);
        end
        total++;
        if (bus.timeout_err !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b want=0", bus.timeout_err);
        end
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", bus.src_ready);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_ready got=%b want=1", bus.src_ready);
        end
    endtask

    task automatic test_first_word;
        int n;
        n = 0;
        bus.src_valid = 1'b1;
        bus.src_data = 8'hA5;
        tick();
        bus.src_valid = 1'b0;
        total++;
        if (bus.tx_req !== 1'b1) begin
            bad++; $display("FAIL first_req got=%b want=1", bus.tx_req);
        end
        total++;
        if (bus.tx_data !== 8'hA5) begin
            bad++; $display("FAIL first_data got=%h want=a5", bus.tx_data);
        end
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (bus.xfer_done === 1'b1) n = i;
        end
        total++;
        if (n != 2 * NS + 2) begin
            bad++; $display("FAIL first_latency got=%0d want=%0d", n, 2 * NS + 2);
        end
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL first_ready_at_done got=%b want=1", bus.src_ready);
        end
        tick();
        total++;
        if (bus.xfer_done !== 1'b0) begin
            bad++; $display("FAIL first_done_width got=%b want=0", bus.xfer_done);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        bus.src_valid = 1'b1;
        bus.src_data = 8'h01;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 7; c++) begin
                total++;
                if (bus.src_ready !== (c == 0)) begin
                    bad++; $display("FAIL b2b_ready w=%0d c=%0d got=%b want=%b",
                                    w, c, bus.src_ready, c == 0);
                end
                tick();
                if (c == 0) begin
                    total++;
                    if (bus.tx_data !== 8'(w + 1) || bus.tx_req !== 1'b1) begin
                        bad++; $display("FAIL b2b_capture w=%0d got=%h/%b want=%h/1",
                                        w, bus.tx_data, bus.tx_req, 8'(w + 1));
                    end
                    if (w < 2) bus.src_data = 8'(w + 2);
                    else bus.src_valid = 1'b0;
                end
                if (bus.xfer_done === 1'b1) pulses++;
            end
        end
        total++;
        if (pulses != 3) begin
            bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses);
        end
    endtask

    task automatic test_hold_data;
        bus.src_valid = 1'b1;
        bus.src_data = 8'hA5;
        tick();
        bus.src_data = 8'hFF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            total++;
            if (bus.tx_data !== 8'hA5) begin
                bad++; $display("FAIL hold_data c=%0d got=%h want=a5", c, bus.tx_data);
            end
        end
        total++;
        if (bus.xfer_done !== 1'b1) begin
            bad++; $display("FAIL hold_done got=%b want=1", bus.xfer_done);
        end
        bus.src_valid = 1'b0;
        tick();
        total++;
        if (bus.tx_data !== 8'hA5 || bus.tx_req !== 1'b0) begin
            bad++; $display("FAIL hold_after got=%h/%b want=a5/0", bus.tx_data, bus.tx_req);
        end
    endtask

    task automatic test_stale_ack;
        ack_mode = 1'b1;
        ack_force = 1'b1;
        tick();
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL stale_ready1 got=%b want=1", bus.src_ready);
        end
        tick();
        total++;
        if (bus.src_ready !== 1'b0) begin
            bad++; $display("FAIL stale_ready2 got=%b want=0", bus.src_ready);
        end
        bus.src_valid = 1'b1;
        bus.src_data = 8'h3C;
        repeat (4) tick();
        total++;
        if (bus.tx_req !== 1'b0 || bus.tx_data !== 8'hA5) begin
            bad++; $display("FAIL stale_no_accept got=%b/%h want=0/a5",
                            bus.tx_req, bus.tx_data);
        end
        ack_force = 1'b0;
        tick();
        total++;
        if (bus.src_ready !== 1'b0) begin
            bad++; $display("FAIL stale_release1 got=%b want=0", bus.src_ready);
        end
        bus.src_valid = 1'b0;
        tick();
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL stale_release2 got=%b want=1", bus.src_ready);
        end
        ack_mode = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int pulses;
        int n;
        pulses = 0;
        n = 0;
        bus.src_valid = 1'b1;
        bus.src_data = 8'h5A;
        tick();
        bus.src_valid = 1'b0;
        tick();
        total++;
        if (bus.tx_req !== 1'b1) begin
            bad++; $display("FAIL mid_req_before got=%b want=1", bus.tx_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.tx_req !== 1'b0 || bus.tx_data !== 8'h00) begin
            bad++; $display("FAIL mid_async_clear got=%b/%h want=0/00",
                            bus.tx_req, bus.tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.xfer_done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL mid_no_done got=%0d want=0", pulses);
        end
        total++;
        if (bus.src_ready !== 1'b1) begin
            bad++; $display("FAIL mid_ready got=%b want=1", bus.src_ready);
        end
        bus.src_valid = 1'b1;
        bus.src_data = 8'h77;
        tick();
        bus.src_valid = 1'b0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (bus.xfer_done === 1'b1) n = i;
        end
        total++;
        if (n != 6 || bus.tx_data !== 8'h77) begin
            bad++; $display("FAIL mid_next_xfer got=%0d/%h want=6/77", n, bus.tx_data);
        end
    endtask

`ifdef CDC_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        n = 0;
        ack_mode = 1'b1;
        ack_force = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data = 8'h9C;
        tick();
        bus.src_valid = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (bus.timeout_err === 1'b1) n = i;
        end
        total++;
        if (n != TO) begin
            bad++; $display("FAIL timeout_cycle got=%0d want=%0d", n, TO);
        end
        total++;
        if (bus.tx_req !== 1'b0 || bus.xfer_done !== 1'b0) begin
            bad++; $display("FAIL timeout_abort got=%b/%b want=0/0",
                            bus.tx_req, bus.xfer_done);
        end
        tick();
        total++;
        if (bus.xfer_done !== 1'b1 || bus.timeout_err !== 1'b0) begin
            bad++; $display("FAIL timeout_done got=%b/%b want=1/0",
                            bus.xfer_done, bus.timeout_err);
        end
        ack_mode = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout;
        int errs;
        int n;
        errs = 0;
        n = 0;
        ack_mode = 1'b1;
        ack_force = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data = 8'h9C;
        tick();
        bus.src_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.timeout_err !== 1'b0) errs++;
        end
        total++;
        if (errs != 0 || bus.tx_req !== 1'b1) begin
            bad++; $display("FAIL no_timeout got=%0d/%b want=0/1", errs, bus.tx_req);
        end
        ack_mode = 1'b0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (bus.xfer_done === 1'b1) n = i;
        end
        total++;
        if (n == 0 || bus.tx_data !== 8'h9C) begin
            bad++; $display("FAIL no_timeout_finish got=%0d/%h want=done/9c",
                            n, bus.tx_data);
        end
        tick();
    endtask
`endif

    // Model: a transfer's age in edges since accept fixes req, done, ready.
    task automatic test_random;
        int       age;
        logic     v;
        logic     mready;
        logic [7:0] d;
        logic [7:0] hold;
        age = -1;
        hold = '0;
        for (int i = 0; i < 300; i++) begin
            v = (i == 0) ? 1'b1 : ($urandom % 4 != 0);
            d = 8'($urandom);
            bus.src_valid = v;
            bus.src_data = d;
            mready = (age < 0 || age >= 2 * NS + 2);
            total++;
            if (bus.src_ready !== mready) begin
                bad++; $display("FAIL rnd_ready i=%0d got=%b want=%b",
                                i, bus.src_ready, mready);
            end
            tick();
            if (mready && v) begin
                age = 0;
                hold = d;
            end else if (age >= 0) begin
                age++;
            end
            total++;
            if (bus.tx_req !== (age >= 0 && age <= NS)) begin
                bad++; $display("FAIL rnd_req i=%0d got=%b want=%b",
                                i, bus.tx_req, age >= 0 && age <= NS);
            end
            total++;
            if (bus.xfer_done !== (age == 2 * NS + 2)) begin
                bad++; $display("FAIL rnd_done i=%0d got=%b want=%b",
                                i, bus.xfer_done, age == 2 * NS + 2);
            end
            total++;
            if (bus.tx_data !== hold || bus.timeout_err !== 1'b0) begin
                bad++; $display("FAIL rnd_data i=%0d got=%h/%b want=%h/0",
                                i, bus.tx_data, bus.timeout_err, hold);
            end
        end
        bus.src_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_hold_data();
        test_stale_ack();
        test_reset_mid();
`ifdef CDC_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
